// File: rtl/hp_smpl_queue_pkg.sv
// Shared types and default sizing for the high-pass sample queue.
package hp_queue_pkg;

  localparam int DW       = 16;
  localparam int DEPTH    = 1024;
  localparam int FILT_LEN = 1021;
  localparam int PTR_W    = $clog2(DEPTH);

  typedef enum logic [1:0] {
    FILL,
    IDLE,
    SEQ
  } queue_state_t;

endpackage

// File: rtl/hp_smpl_queue_dpram.sv
// Sample storage: one write port, one registered read port with read enable.
// Left channel sits in the upper half of each word, right channel in the lower half.
module smpl_dpram #(
  parameter  int WW    = 32,
  parameter  int DEPTH = 1024,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [WW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [WW-1:0] rdata_o
);

  logic [WW-1:0] mem_q [DEPTH];
  logic [WW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Only the output register is reset; it holds its value while reads are idle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/hp_smpl_queue.sv
// Circular stereo sample buffer feeding the high-pass FIR with sliding windows.
// Optional macro HP_SMPL_QUEUE_DROP_CNT_EN enables the saturating drop counter.
module hp_smpl_queue #(
  parameter int DW       = hp_queue_pkg::DW,
  parameter int DEPTH    = hp_queue_pkg::DEPTH,
  parameter int FILT_LEN = hp_queue_pkg::FILT_LEN
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wrt_smpl,
  input  logic [DW-1:0] lft_new_smpl,
  input  logic [DW-1:0] rht_new_smpl,
  output logic          sequencing,
  output logic [DW-1:0] lft_smpl_out,
  output logic [DW-1:0] rht_smpl_out,
  output logic          full,
  output logic          ovrflw,
  output logic [15:0]   drop_cnt
);

  import hp_queue_pkg::*;

  localparam int            AW   = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(FILT_LEN - 1);

  queue_state_t  state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] new_ptr_q, new_ptr_d;
  logic [AW-1:0] old_ptr_q, old_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] seq_cnt_q, seq_cnt_d;
  logic          pending_q, pending_d;
  logic          ovrflw_q;
  logic          we, drop, rd_en;
  logic [2*DW-1:0] rd_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FILL;
      cnt_q     <= '0;
      new_ptr_q <= '0;
      old_ptr_q <= '0;
      rd_ptr_q  <= '0;
      seq_cnt_q <= '0;
      pending_q <= 1'b0;
      ovrflw_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      new_ptr_q <= new_ptr_d;
      old_ptr_q <= old_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      seq_cnt_q <= seq_cnt_d;
      pending_q <= pending_d;
      ovrflw_q  <= drop;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    new_ptr_d = new_ptr_q;
    old_ptr_d = old_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    seq_cnt_d = seq_cnt_q;
    pending_d = pending_q;
    we        = 1'b0;
    drop      = 1'b0;
    unique case (state_q)
      FILL: begin
        if (wrt_smpl) begin
          we    = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) state_d = IDLE;
        end
      end
      // A window owed by a write seen during the previous window starts here,
      // which is what produces the single low cycle between back-to-back windows.
      IDLE: begin
        we = wrt_smpl;
        if (wrt_smpl || pending_q) begin
          state_d   = SEQ;
          old_ptr_d = old_ptr_q + 1'b1;
          rd_ptr_d  = old_ptr_q + 1'b1;
          seq_cnt_d = '0;
          pending_d = pending_q & wrt_smpl;
        end
      end
      SEQ: begin
        rd_ptr_d  = rd_ptr_q + 1'b1;
        seq_cnt_d = seq_cnt_q + 1'b1;
        if (wrt_smpl) begin
          if (!pending_q) begin
            we        = 1'b1;
            pending_d = 1'b1;
          end else begin
            drop = 1'b1;
          end
        end
        if (seq_cnt_q == LAST) state_d = IDLE;
      end
      default: state_d = FILL;
    endcase
    if (we) new_ptr_d = new_ptr_q + 1'b1;
  end

  assign rd_en = (state_q == SEQ);

  smpl_dpram #(
    .WW    (2 * DW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (we),
    .waddr_i (new_ptr_q),
    .wdata_i ({lft_new_smpl, rht_new_smpl}),
    .re_i    (rd_en),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  assign sequencing   = rd_en;
  assign full         = (state_q != FILL);
  assign ovrflw       = ovrflw_q;
  assign lft_smpl_out = rd_data[2*DW-1:DW];
  assign rht_smpl_out = rd_data[DW-1:0];

`ifdef HP_SMPL_QUEUE_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             drop_cnt_q <= '0;
    else if (drop && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + 1'b1;
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_hp_smpl_queue.sv
// Directed bench for hp_smpl_queue, scaled to DEPTH=16 / FILT_LEN=13 for short runs.
module tb_hp_smpl_queue;

  localparam int DW = 16;
  localparam int DP = 16;
  localparam int FL = 13;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wrt_smpl = 1'b0;
  logic [DW-1:0] lft_new_smpl = '0;
  logic [DW-1:0] rht_new_smpl = '0;
  logic          sequencing;
  logic [DW-1:0] lft_smpl_out, rht_smpl_out;
  logic          full, ovrflw;
  logic [15:0]   drop_cnt;

  int checks = 0;
  int errors = 0;

  hp_smpl_queue #(.DW(DW), .DEPTH(DP), .FILT_LEN(FL)) dut (
    .clk          (clk),
    .rst          (rst),
    .wrt_smpl     (wrt_smpl),
    .lft_new_smpl (lft_new_smpl),
    .rht_new_smpl (rht_new_smpl),
    .sequencing   (sequencing),
    .lft_smpl_out (lft_smpl_out),
    .rht_smpl_out (rht_smpl_out),
    .full         (full),
    .ovrflw       (ovrflw),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;

  // Monitor: captures the sample stream one cycle behind sequencing.
  logic [DW-1:0] cap_l [0:2047];
  logic [DW-1:0] cap_r [0:2047];
  int cap_n = 0, win_n = 0, run_cur = 0, gap_cur = 0, seq_cycles = 0, ovf_n = 0;
  int runs [0:255];
  int gaps [0:255];
  logic prev_seq = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_seq <= 1'b0;
      run_cur  <= 0;
      gap_cur  <= 0;
    end else begin
      prev_seq <= sequencing;
      if (prev_seq) begin
        cap_l[cap_n] <= lft_smpl_out;
        cap_r[cap_n] <= rht_smpl_out;
        cap_n        <= cap_n + 1;
      end
      if (sequencing) begin
        seq_cycles <= seq_cycles + 1;
        run_cur    <= run_cur + 1;
        if (!prev_seq) begin
          gaps[win_n] <= gap_cur;
          gap_cur     <= 0;
        end
      end else begin
        gap_cur <= gap_cur + 1;
        if (run_cur != 0) begin
          runs[win_n] <= run_cur;
          win_n       <= win_n + 1;
          run_cur     <= 0;
        end
      end
      if (ovrflw) ovf_n <= ovf_n + 1;
    end
  end

  // Model: list of accepted samples; a window is the last FL accepted values.
  logic [DW-1:0] acc [0:255];
  int acc_n = 0;

  task automatic do_write(input logic [DW-1:0] v);
    @(negedge clk);
    wrt_smpl     = 1'b1;
    lft_new_smpl = v;
    rht_new_smpl = v + 16'h4000;
    @(negedge clk);
    wrt_smpl = 1'b0;
  endtask

  task automatic accept(input logic [DW-1:0] v);
    acc[acc_n] = v;
    acc_n++;
  endtask

  task automatic wait_win(input int target, input int budget, output bit ok);
    int n = 0;
    while (win_n < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    ok = (win_n >= target);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++; if (sequencing !== 1'b0) begin errors++; $display("FAIL reset_seq got %b want 0", sequencing); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full); end
    checks++; if (ovrflw !== 1'b0) begin errors++; $display("FAIL reset_ovrflw got %b want 0", ovrflw); end
    checks++; if (lft_smpl_out !== 16'h0) begin errors++; $display("FAIL reset_lft got %h want 0000", lft_smpl_out); end
    checks++; if (rht_smpl_out !== 16'h0) begin errors++; $display("FAIL reset_rht got %h want 0000", rht_smpl_out); end
    checks++; if (drop_cnt !== 16'h0) begin errors++; $display("FAIL reset_drop_cnt got %h want 0000", drop_cnt); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fill(input int base_v);
    int s0;
    #1;
    s0 = seq_cycles;
    for (int i = 0; i < FL - 1; i++) begin
      do_write(16'(base_v + i));
      accept(16'(base_v + i));
    end
    #1;
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL fill_partial_full got %b want 0", full); end
    do_write(16'(base_v + FL - 1));
    accept(16'(base_v + FL - 1));
    #1;
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full got %b want 1", full); end
    repeat (20) @(negedge clk);
    #1;
    checks++; if (seq_cycles != s0) begin errors++; $display("FAIL fill_no_seq got %0d seq cycles want 0", seq_cycles - s0); end
  endtask

  // Writes one sample from IDLE and checks the window it triggers.
  task automatic test_window(input logic [DW-1:0] v, input string nm);
    int mark, w0;
    bit ok;
    #1;
    mark = cap_n;
    w0   = win_n;
    do_write(v);
    accept(v);
    wait_win(w0 + 1, 60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL %s_timeout got no window want 1", nm); end
    else begin
      checks++; if (runs[w0] != FL) begin errors++; $display("FAIL %s_len got %0d want %0d", nm, runs[w0], FL); end
      for (int k = 0; k < FL; k++) begin
        checks++;
        if (cap_l[mark + k] !== acc[acc_n - FL + k] || cap_r[mark + k] !== 16'(acc[acc_n - FL + k] + 16'h4000)) begin
          errors++;
          $display("FAIL %s_smpl%0d got %h/%h want %h/%h", nm, k, cap_l[mark + k], cap_r[mark + k],
                   acc[acc_n - FL + k], 16'(acc[acc_n - FL + k] + 16'h4000));
        end
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 30; i++) test_window(16'(14 + i), "wrap");
  endtask

  task automatic test_pending();
    int mark, w0;
    bit ok;
    #1;
    mark = cap_n;
    w0   = win_n;
    do_write(16'd44);
    accept(16'd44);
    repeat (9) @(negedge clk);
    do_write(16'd45);
    accept(16'd45);
    wait_win(w0 + 2, 80, ok);
    checks++; if (!ok) begin errors++; $display("FAIL pend_timeout got %0d windows want 2", win_n - w0); end
    else begin
      checks++; if (gaps[w0 + 1] != 1) begin errors++; $display("FAIL pend_gap got %0d want 1", gaps[w0 + 1]); end
      checks++; if (runs[w0 + 1] != FL) begin errors++; $display("FAIL pend_len got %0d want %0d", runs[w0 + 1], FL); end
      for (int k = 0; k < 2 * FL; k++) begin
        int idx = (k < FL) ? (acc_n - 1 - FL + k) : (acc_n - 2 * FL + k);
        checks++;
        if (cap_l[mark + k] !== acc[idx]) begin
          errors++;
          $display("FAIL pend_smpl%0d got %h want %h", k, cap_l[mark + k], acc[idx]);
        end
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_overflow();
    int mark, w0, o0;
    bit ok;
    #1;
    mark = cap_n;
    w0   = win_n;
    o0   = ovf_n;
    do_write(16'd46);
    accept(16'd46);
    repeat (2) @(negedge clk);
    do_write(16'd47);
    accept(16'd47);
    repeat (2) @(negedge clk);
    do_write(16'd48);
    wait_win(w0 + 2, 80, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ovf_timeout got %0d windows want 2", win_n - w0); end
    repeat (30) @(negedge clk);
    #1;
    checks++; if (win_n != w0 + 2) begin errors++; $display("FAIL ovf_windows got %0d want 2", win_n - w0); end
    checks++; if (ovf_n != o0 + 1) begin errors++; $display("FAIL ovf_pulses got %0d want 1", ovf_n - o0); end
`ifdef HP_SMPL_QUEUE_DROP_CNT_EN
    checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL ovf_drop_cnt got %0d want 1", drop_cnt); end
`else
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL ovf_drop_cnt got %0d want 0", drop_cnt); end
`endif
    for (int k = 0; k < FL; k++) begin
      checks++;
      if (cap_l[mark + FL + k] !== acc[acc_n - FL + k]) begin
        errors++;
        $display("FAIL ovf_win2_smpl%0d got %h want %h", k, cap_l[mark + FL + k], acc[acc_n - FL + k]);
      end
    end
    test_window(16'd49, "post_ovf");
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_write(16'd50);
    repeat (6) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (sequencing !== 1'b0) begin errors++; $display("FAIL rmid_seq got %b want 0", sequencing); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL rmid_full got %b want 0", full); end
    checks++; if (lft_smpl_out !== 16'h0 || rht_smpl_out !== 16'h0) begin
      errors++; $display("FAIL rmid_outs got %h/%h want 0000/0000", lft_smpl_out, rht_smpl_out);
    end
    checks++; if (drop_cnt !== 16'h0) begin errors++; $display("FAIL rmid_drop_cnt got %h want 0000", drop_cnt); end
    repeat (2) @(negedge clk);
    rst   = 1'b0;
    acc_n = 0;
    test_fill(100);
    test_window(16'd113, "refill");
  endtask

  initial begin
    test_reset();
    test_fill(0);
    test_window(16'd13, "first");
    test_wrap();
    test_pending();
    test_overflow();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got no finish want finish");
    $fatal(1);
  end

endmodule

// File: doc/hp_smpl_queue.md
Name: hp_smpl_queue

Overview:
- Circular sample buffer directly upstream of the high-pass FIR engine.
- Stores the most recent FILT_LEN stereo samples from the codec interface.
- On every new sample, once full, it streams all FILT_LEN samples (oldest to newest) to the FIR with a `sequencing` strobe.
- Drops the oldest sample per sequence, so the FIR sees a sliding window.

Parameters:
- DW, 16, sample width per channel (signed).
- DEPTH, 1024, physical buffer entries (power of two).
- FILT_LEN, 1021, samples per FIR window; must be less than DEPTH.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- wrt_smpl  in  1  one-cycle pulse: new sample pair valid.
- lft_new_smpl  in  DW  incoming left sample.
- rht_new_smpl  in  DW  incoming right sample.
- sequencing  out  1  high for exactly FILT_LEN cycles per window.
- lft_smpl_out  out  DW  left sample to FIR.
- rht_smpl_out  out  DW  right sample to FIR.
- full  out  1  buffer holds FILT_LEN samples.
- ovrflw  out  1  one-cycle pulse: a sample was dropped.
- drop_cnt  out  16  dropped-sample count (see Optional Feature).

Behaviour:
- Reset (async, any state):
  - new_ptr=old_ptr=rd_ptr=0, cnt=0, pending=0, state=FILL.
  - sequencing=0, full=0, ovrflw=0, smpl outs=0, drop_cnt=0.
  - Memory contents are don't-care.
  - Reset mid-sequence aborts immediately; sequencing falls asynchronously.
- Write path: on wrt_smpl (not dropped), {lft,rht} is written at new_ptr, then new_ptr <= (new_ptr+1) mod DEPTH.
- FILL state:
  - Writes only; cnt increments per write.
  - A write that makes cnt==FILT_LEN sets full=1 and goes to IDLE. No sequence is started by the filling write.
- IDLE state:
  - On wrt_smpl: write the sample; next cycle enter SEQ with rd_ptr=old_ptr+1 (mod DEPTH). This discards the oldest sample.
  - old_ptr advances by 1 at the same time.
  - cnt stays FILT_LEN.
- SEQ state:
  - sequencing=1 for FILT_LEN consecutive cycles.
  - Synchronous read; rd_ptr increments mod DEPTH each cycle.
  - smpl outs are registered, so sample k (k=0 oldest) is valid in the cycle after the k-th sequencing cycle. Outputs lag sequencing by 1 clk, which aligns with the FIR's one-cycle-delayed accumulate.
  - The last sample read is the newest written.
- SEQ exit:
  - If pending=1: clear pending and go straight back into SEQ (new window, old_ptr+1). sequencing then drops for exactly 1 cycle between windows.
  - Otherwise go to IDLE.
- wrt_smpl during SEQ:
  - If pending=0: write the sample (spare slots DEPTH-FILT_LEN guarantee no collision with unread data) and set pending=1.
  - If pending=1: the sample is not written, ovrflw pulses, and drop_cnt increments.
- Pointer wrap: all pointer arithmetic is mod DEPTH. Wrap across DEPTH-1 to 0 must be seamless mid-window.
- Hold behaviour: smpl outs hold their last value when not sequencing.

Optional Feature:
- Macro: HP_SMPL_QUEUE_DROP_CNT_EN.
- Defined: drop_cnt is a 16-bit counter, incremented on each ovrflw, saturating at 16'hFFFF, cleared only by rst.
- Undefined: drop_cnt tied to 16'h0000 and no counter is synthesized. ovrflw still works.

Decomposition:
- Package hp_queue_pkg:
  - localparams DW, DEPTH, FILT_LEN, PTR_W=$clog2(DEPTH).
  - enum typedef queue_state_t {FILL, IDLE, SEQ}.
- One sub-module, smpl_dpram:
  - DEPTH x 2*DW storage.
  - One write port, one registered synchronous read port, no reset on the array.
  - Left channel in the upper half of each word, right channel in the lower half.

Test Plan:
- Fill: 1020 wrt_smpl pulses of value n -> full=0, sequencing never asserts. 1021st pulse -> full=1, still no sequencing.
- First window: after fill, write 1021 -> sequencing high exactly 1021 cycles. lft_smpl_out shows 1,2,...,1021 one cycle behind sequencing. Sample 0 is never output.
- Wrap: run 1100 more writes, spaced 1100 cycles apart -> each window is strictly consecutive values ending at the newest, including across the pointer wrap at 1023->0.
- Pending: a wrt_smpl 10 cycles into a window -> that window completes unchanged; sequencing low 1 cycle; next window starts shifted by one.
- Overflow: two wrt_smpl during one window -> the second is dropped, ovrflw pulses once, drop_cnt=1 with the macro defined (0 without). The following window contains no dropped value.
- Reset mid-window: assert rst at cycle 500 of a window -> sequencing=0, full=0, outputs 0 immediately. Refill of 1021 then behaves as in the first two scenarios.
